// File: rtl/em4100_encoder.sv
// EM4100 tag bitstream generator: builds the 64-bit frame from a 40-bit ID
// and Manchester-encodes it onto a single registered output. Frames repeat
// back-to-back while tx is held high.
module em4100_encoder #(
    parameter int HALF_BIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx,
    input  logic [39:0] data,
    output logic        q
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int CW = $clog2(2 * HALF_BIT_CYCLES);
    localparam logic [CW-1:0] HALF_LAST = CW'(2 * HALF_BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_MID  = CW'(HALF_BIT_CYCLES);

    // Frame layout: index 0 is transmitted first.
    function automatic logic [63:0] build_frame(input logic [39:0] d);
        logic [63:0] f;
        logic [3:0]  nib;
        logic [3:0]  col;
        f       = 64'd0;
        f[8:0]  = 9'h1FF;
        col     = 4'd0;
        for (int r = 0; r < 10; r++) begin
            nib          = d[39-4*r -: 4];
            f[9 + 5*r]   = nib[3];
            f[10 + 5*r]  = nib[2];
            f[11 + 5*r]  = nib[1];
            f[12 + 5*r]  = nib[0];
            f[13 + 5*r]  = ^nib;
            col          = col ^ nib;
        end
        f[59] = col[3];
        f[60] = col[2];
        f[61] = col[1];
        f[62] = col[0];
        f[63] = 1'b0;
        return f;
    endfunction

    state_t          state_q, state_d;
    logic [63:0]     frame_q, frame_d;
    logic [5:0]      bit_q,   bit_d;
    logic [CW-1:0]   half_q,  half_d;
    logic            q_q,     q_d;
    logic [63:0]     captured_s;

    assign captured_s = build_frame(data);
    assign q          = q_q;

    // Next-state logic: counters, frame capture and the Manchester output.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        bit_d   = bit_q;
        half_d  = half_q;
        q_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx) begin
                    frame_d = captured_s;
                    bit_d   = 6'd0;
                    half_d  = '0;
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (half_q == HALF_LAST) begin
                    half_d = '0;
                    if (bit_q == 6'd63) begin
                        bit_d = 6'd0;
                        if (tx) begin
                            frame_d = captured_s;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 6'd1;
                    end
                end else begin
                    half_d = half_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                bit_d   = 6'd0;
                half_d  = '0;
            end
        endcase
        // Output reflects the bit/half that the next cycle belongs to, so the
        // first half of bit 0 is visible right after the capture edge.
        if (state_d == SEND) begin
            q_d = frame_d[bit_d] ^ (half_d >= HALF_MID);
        end else begin
            q_d = 1'b0;
        end
    end

    // State, counter, frame and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            frame_q <= 64'd0;
            bit_q   <= 6'd0;
            half_q  <= '0;
            q_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            q_q     <= q_d;
        end
    end

endmodule

// File: tb/tb_em4100_encoder.sv
// Self-checking bench for em4100_encoder: table-driven single frames plus
// hand-written back-to-back, reset and slow-clock sequences.
module tb_em4100_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx1, tx32;
    logic [39:0] data1, data32;
    logic        q1, q32;

    int n_checks = 0;
    int n_fail   = 0;

    em4100_encoder #(.HALF_BIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .tx(tx1), .data(data1), .q(q1)
    );

    em4100_encoder #(.HALF_BIT_CYCLES(32)) dut32 (
        .clk(clk), .rst(rst), .tx(tx32), .data(data32), .q(q32)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] data;
        logic [63:0] frame;   // MSB = first transmitted bit
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] manch(input logic [63:0] f);
        logic [127:0] w;
        for (int i = 0; i < 64; i++) begin
            w[127-2*i] = f[63-i];
            w[126-2*i] = ~f[63-i];
        end
        return w;
    endfunction

    logic [127:0] wave_a, wave_b, wave_s;
    logic [3:0]   idle_w;
    logic         prev;
    int           viol;

    initial begin
        vecs[0].data  = 40'h00DEADBEEF;
        vecs[0].frame = 64'b111111111_00000_00000_11011_11101_10100_11011_10111_11101_11101_11110_0000_0;
        vecs[1].data  = 40'h0000000000;
        vecs[1].frame = 64'b111111111_00000_00000_00000_00000_00000_00000_00000_00000_00000_00000_0000_0;
        vecs[2].data  = 40'h0123456789;
        vecs[2].frame = 64'b111111111_00000_00011_00101_00110_01001_01010_01100_01111_10001_10010_0001_0;
        vecs[3].data  = 40'hFFFFFFFFFF;
        vecs[3].frame = 64'b111111111_11110_11110_11110_11110_11110_11110_11110_11110_11110_11110_0000_0;

        rst = 1'b1; tx1 = 1'b0; tx32 = 1'b0; data1 = 40'd0; data32 = 40'd0;
        #1;
        check("reset_q1", {127'd0, q1}, 128'd0);
        check("reset_q32", {127'd0, q32}, 128'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single frames from the table; tx dropped right after capture.
        for (int v = 0; v < 4; v++) begin
            data1 = vecs[v].data;
            tx1   = 1'b1;
            for (int i = 0; i < 128; i++) begin
                @(negedge clk);
                tx1 = 1'b0;
                if (i == 10) data1 = ~vecs[v].data;
                wave_a[127-i] = q1;
            end
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                idle_w[i] = q1;
            end
            check($sformatf("frame_vec%0d", v), wave_a, manch(vecs[v].frame));
            check($sformatf("idle_after_vec%0d", v), {124'd0, idle_w}, 128'd0);
        end

        // Back-to-back: data changes mid-frame, second frame carries it, tx
        // dropped at bit 20 of the second frame.
        data1 = vecs[0].data;
        tx1   = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (i == 40) data1 = vecs[2].data;
            if (i == 128 + 40) tx1 = 1'b0;
            if (i < 128) wave_a[127-i] = q1;
            else         wave_b[255-i] = q1;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_w[i] = q1;
        end
        check("b2b_first", wave_a, manch(vecs[0].frame));
        check("b2b_second", wave_b, manch(vecs[2].frame));
        check("b2b_idle", {124'd0, idle_w}, 128'd0);

        // Asynchronous reset mid-frame with tx still high.
        data1 = vecs[3].data;
        tx1   = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("pre_reset_high", {127'd0, q1}, 128'd1);
        rst = 1'b1;
        #1;
        check("async_reset", {127'd0, q1}, 128'd0);
        tx1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_w[i] = q1;
        end
        check("post_reset_idle", {124'd0, idle_w}, 128'd0);

        // Slow clock: 32 cycles per half-bit, 4096 cycles per frame.
        data32 = vecs[0].data;
        tx32   = 1'b1;
        prev   = 1'b0;
        viol   = 0;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            tx32 = 1'b0;
            if ((i % 32) != 0 && q32 !== prev) viol++;
            if ((i % 32) == 0) wave_s[127-(i/32)] = q32;
            prev = q32;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_w[i] = q32;
        end
        check("h32_boundaries", 128'(viol), 128'd0);
        check("h32_frame", wave_s, manch(vecs[0].frame));
        check("h32_idle", {124'd0, idle_w}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
